// File: rtl/program_loader_pkg.sv
// program_loader_pkg
//   Shared definitions for the program loader and the blocks around it.
//   - TEXT_BASE    : byte address of instruction word 0. Program memory and
//                    the PC reset value use the same constant.
//   - HEADER_WIDTH : width of the word-count header that precedes the image.
//   - state_t      : loader FSM state encoding.
package program_loader_pkg;

    localparam logic [31:0] TEXT_BASE    = 32'h0040_0000;
    localparam int          HEADER_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// byte_packer
//   Collects four stream bytes, MSB first, into one word.
//   Ports:
//     clk           in   system clock, rising edge
//     reset         in   asynchronous, active-low reset
//     clear         in   restart the byte count (start of a new image)
//     shift         in   a byte is transferred this cycle
//     stream_byte   in   the byte being transferred
//     word_next     out  shift register contents including stream_byte
//     word_complete out  pulse: this transfer is the 4th byte of a word
module byte_packer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic [7:0]       stream_byte,
    output logic [WIDTH-1:0] word_next,
    output logic             word_complete
);

    logic [1:0]       count_reg;
    logic [WIDTH-1:0] word_reg;

    // Bytes enter from the LSB side, so the first byte of a word ends up in
    // the most significant position after the 4th shift.
    assign word_next     = {word_reg[WIDTH-9:0], stream_byte};
    assign word_complete = shift && (count_reg == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 2'd0;
            word_reg  <= '0;
        end else if (clear) begin
            count_reg <= 2'd0;
        end else if (shift) begin
            // The 2-bit counter wraps back to 0 after the 4th byte.
            count_reg <= count_reg + 2'd1;
            word_reg  <= word_next;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction memory. Receives a byte stream made of a
//   16-bit word count N (MSB first) followed by N big-endian 32-bit words,
//   writes each word to BASE_ADDRESS + 4*index and holds the CPU until the
//   whole image has been written.
//   Ports:
//     clk           in   system clock, rising edge
//     reset         in   asynchronous, active-low reset
//     Start_i       in   one-cycle pulse, begins a load session
//     Byte_i        in   stream byte
//     Byte_Valid_i  in   Byte_i valid this cycle
//     Byte_Ready_o  out  loader accepts a byte this cycle
//     Mem_Write_o   out  program memory write strobe
//     Mem_Address_o out  byte address of the word being written
//     Mem_Data_o    out  word being written
//     Cpu_Hold_o    out  processor held while 1
//     Done_o        out  image loaded (level)
//     Error_o       out  header rejected (level)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(TEXT_BASE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [7:0]            Byte_i,
    input  logic                  Byte_Valid_i,
    output logic                  Byte_Ready_o,
    output logic                  Mem_Write_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Data_o,
    output logic                  Cpu_Hold_o,
    output logic                  Done_o,
    output logic                  Error_o
);

    localparam logic [HEADER_WIDTH:0] DEPTH_LIMIT = (HEADER_WIDTH + 1)'(MEMORY_DEPTH);

    state_t                  state_reg, state_next;
    logic [7:0]              len_hi_reg;
    logic [HEADER_WIDTH-1:0] word_count_reg;
    logic [HEADER_WIDTH-1:0] index_reg;
    logic [DATA_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   data_reg;

    logic                    xfer;
    logic [HEADER_WIDTH-1:0] header_value;
    logic                    header_bad;
    logic [HEADER_WIDTH-1:0] index_inc;
    logic [DATA_WIDTH-1:0]   word_addr;
    logic [DATA_WIDTH-1:0]   word_next;
    logic                    word_complete;

    assign xfer         = Byte_Valid_i && Byte_Ready_o;
    assign header_value = {len_hi_reg, Byte_i};
    assign header_bad   = (header_value == '0) || ({1'b0, header_value} > DEPTH_LIMIT);
    assign index_inc    = index_reg + 1'b1;
    assign word_addr    = BASE_ADDRESS + (DATA_WIDTH'(index_reg) << 2);

    byte_packer #(
        .WIDTH(DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (state_reg == LEN_LO),
        .shift        (xfer && (state_reg == DATA)),
        .stream_byte  (Byte_i),
        .word_next    (word_next),
        .word_complete(word_complete)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Start_i is only honoured in IDLE, DONE and ERROR,
    // so a running session cannot be aborted except by reset.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:   if (Start_i) state_next = LEN_HI;
            LEN_HI: if (xfer) state_next = LEN_LO;
            LEN_LO: if (xfer) state_next = header_bad ? ERROR : DATA;
            DATA:   if (word_complete) state_next = WRITE;
            WRITE:  state_next = (index_inc == word_count_reg) ? DONE : DATA;
            DONE:   if (Start_i) state_next = LEN_HI;
            ERROR:  if (Start_i) state_next = LEN_HI;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the state alone, so Done_o/Error_o clear and
    // Cpu_Hold_o re-asserts as soon as a new session enters LEN_HI.
    always_comb begin
        Byte_Ready_o = 1'b0;
        Mem_Write_o  = 1'b0;
        Done_o       = 1'b0;
        Error_o      = 1'b0;
        Cpu_Hold_o   = 1'b1;
        unique case (state_reg)
            LEN_HI, LEN_LO, DATA: Byte_Ready_o = 1'b1;
            WRITE:                Mem_Write_o  = 1'b1;
            DONE: begin
                Done_o     = 1'b1;
                Cpu_Hold_o = 1'b0;
            end
            ERROR:                Error_o      = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header capture, word index and the write address/data
    // registers. Address and data are loaded on the 4th byte so they are
    // valid throughout the single WRITE cycle and hold afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_hi_reg     <= 8'd0;
            word_count_reg <= '0;
            index_reg      <= '0;
            addr_reg       <= BASE_ADDRESS;
            data_reg       <= '0;
        end else begin
            if ((state_reg == LEN_HI) && xfer) begin
                len_hi_reg <= Byte_i;
            end
            if ((state_reg == LEN_LO) && xfer) begin
                word_count_reg <= header_value;
                index_reg      <= '0;
            end
            if (word_complete) begin
                addr_reg <= word_addr;
                data_reg <= word_next;
            end
            if (state_reg == WRITE) begin
                index_reg <= index_inc;
            end
        end
    end

    assign Mem_Address_o = addr_reg;
    assign Mem_Data_o    = data_reg;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Directed bench for program_loader: a table of header/image sessions
//   applied in a loop, plus hand-written sequences for write latency,
//   throttled sources, full depth and reset in the middle of a word.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start_i = 1'b0;
    logic [7:0]  Byte_i = 8'h00;
    logic        Byte_Valid_i = 1'b0;
    logic        Byte_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Data_o;
    logic        Cpu_Hold_o;
    logic        Done_o;
    logic        Error_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_exp;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        bit         exp_err;
        int         n_words;
        bit         throttle;
    } hdr_vec_t;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .Start_i      (Start_i),
        .Byte_i       (Byte_i),
        .Byte_Valid_i (Byte_Valid_i),
        .Byte_Ready_o (Byte_Ready_o),
        .Mem_Write_o  (Mem_Write_o),
        .Mem_Address_o(Mem_Address_o),
        .Mem_Data_o   (Mem_Data_o),
        .Cpu_Hold_o   (Cpu_Hold_o),
        .Done_o       (Done_o),
        .Error_o      (Error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (Mem_Write_o) begin
            $display("write addr=%h data=%h", Mem_Address_o, Mem_Data_o);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write",
                         Mem_Address_o, Mem_Data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("write_addr", Mem_Address_o, mon_exp.addr);
                check("write_data", Mem_Data_o, mon_exp.data);
            end
            check("ready_during_write", {31'd0, Byte_Ready_o}, 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one byte and wait until it is actually transferred.
    task automatic send_byte(input logic [7:0] b, input bit throttle);
        bit sent;
        sent = 1'b0;
        if (throttle) begin
            Byte_Valid_i = 1'b0;
            step(1);
        end
        Byte_i       = b;
        Byte_Valid_i = 1'b1;
        for (int k = 0; k < 16 && !sent; k++) begin
            sent = Byte_Ready_o;
            step(1);
        end
        if (!sent) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got no transfer of %h, required one within 16 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit throttle);
        send_byte(w[31:24], throttle);
        send_byte(w[23:16], throttle);
        send_byte(w[15:8], throttle);
        send_byte(w[7:0], throttle);
    endtask

    task automatic start_session();
        Byte_Valid_i = 1'b0;
        Start_i      = 1'b1;
        step(1);
        Start_i = 1'b0;
        check("start_done_clear", {31'd0, Done_o}, 32'd0);
        check("start_error_clear", {31'd0, Error_o}, 32'd0);
        check("start_hold", {31'd0, Cpu_Hold_o}, 32'd1);
        check("start_ready", {31'd0, Byte_Ready_o}, 32'd1);
    endtask

    task automatic check_end(input string tag, input bit exp_err);
        Byte_Valid_i = 1'b0;
        step(2);
        check({tag, "_error"}, {31'd0, Error_o}, {31'd0, exp_err});
        check({tag, "_done"}, {31'd0, Done_o}, {31'd0, !exp_err});
        check({tag, "_hold"}, {31'd0, Cpu_Hold_o}, {31'd0, exp_err});
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hdr_vec_t    vecs[6];
        logic [7:0]  stream[10];
        logic [31:0] w;

        vecs[0] = '{8'h00, 8'h00, 1'b1, 0, 1'b0};
        vecs[1] = '{8'h00, 8'h41, 1'b1, 0, 1'b0};
        vecs[2] = '{8'h01, 8'h00, 1'b1, 0, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 0, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 1'b0, 1, 1'b0};
        vecs[5] = '{8'h00, 8'h03, 1'b0, 3, 1'b1};

        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};

        // Reset state
        step(2);
        check("rst_hold", {31'd0, Cpu_Hold_o}, 32'd1);
        check("rst_done", {31'd0, Done_o}, 32'd0);
        check("rst_error", {31'd0, Error_o}, 32'd0);
        check("rst_write", {31'd0, Mem_Write_o}, 32'd0);
        check("rst_ready", {31'd0, Byte_Ready_o}, 32'd0);
        check("rst_addr", Mem_Address_o, BASE);
        check("rst_data", Mem_Data_o, 32'd0);
        reset = 1'b1;

        // Bytes offered in IDLE are never accepted
        Byte_i       = 8'h55;
        Byte_Valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("idle_ready", {31'd0, Byte_Ready_o}, 32'd0);
        end
        Byte_Valid_i = 1'b0;

        // Two-word load, streaming then throttled
        for (int t = 0; t < 2; t++) begin
            start_session();
            exp_q.push_back('{BASE, 32'h2008_0005});
            exp_q.push_back('{BASE + 32'd4, 32'hAC08_0000});
            for (int i = 0; i < 10; i++) begin
                send_byte(stream[i], t[0]);
                if (i == 5) begin
                    check("w1_latency", {31'd0, Mem_Write_o}, 32'd1);
                    check("w1_addr", Mem_Address_o, BASE);
                    check("w1_data", Mem_Data_o, 32'h2008_0005);
                end
                if (i == 9) begin
                    check("w2_latency", {31'd0, Mem_Write_o}, 32'd1);
                    check("w2_addr", Mem_Address_o, BASE + 32'd4);
                    check("w2_data", Mem_Data_o, 32'hAC08_0000);
                end
            end
            check_end(t == 0 ? "two_word" : "throttled", 1'b0);
        end

        // Header table: rejected and accepted word counts
        for (int v = 0; v < 6; v++) begin
            start_session();
            send_byte(vecs[v].hi, vecs[v].throttle);
            send_byte(vecs[v].lo, vecs[v].throttle);
            for (int n = 0; n < vecs[v].n_words; n++) begin
                w = {8'(v), 8'(n), 8'hC3, 8'(~n)};
                exp_q.push_back('{BASE + 32'(n * 4), w});
                send_word(w, vecs[v].throttle);
            end
            check_end($sformatf("hdr%0d", v), vecs[v].exp_err);
            check($sformatf("hdr%0d_no_write", v), {31'd0, Mem_Write_o}, 32'd0);
        end

        // Full depth with a Start_i pulse in the middle of the image
        start_session();
        send_byte(8'h00, 1'b0);
        send_byte(8'h40, 1'b0);
        for (int n = 0; n < 64; n++) begin
            if (n == 30) begin
                Byte_Valid_i = 1'b0;
                Start_i      = 1'b1;
                step(1);
                Start_i = 1'b0;
                check("mid_start_ignored_ready", {31'd0, Byte_Ready_o}, 32'd1);
            end
            exp_q.push_back('{BASE + 32'(n * 4), 32'(n + 1)});
            send_word(32'(n + 1), 1'b0);
        end
        check_end("full_depth", 1'b0);
        check("full_last_addr", Mem_Address_o, 32'h0040_00FC);
        check("full_last_data", Mem_Data_o, 32'd64);

        // Reset in the middle of a word
        start_session();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        Byte_Valid_i = 1'b0;
        reset = 1'b0;
        #2;
        check("midrst_hold", {31'd0, Cpu_Hold_o}, 32'd1);
        check("midrst_ready", {31'd0, Byte_Ready_o}, 32'd0);
        check("midrst_write", {31'd0, Mem_Write_o}, 32'd0);
        check("midrst_done", {31'd0, Done_o}, 32'd0);
        check("midrst_addr", Mem_Address_o, BASE);
        step(1);
        reset = 1'b1;
        step(3);
        check("midrst_idle_ready", {31'd0, Byte_Ready_o}, 32'd0);
        start_session();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        exp_q.push_back('{BASE, 32'hDEAD_BEEF});
        send_word(32'hDEAD_BEEF, 1'b0);
        check("after_rst_write", {31'd0, Mem_Write_o}, 32'd1);
        check_end("after_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction memory: takes a byte stream (e.g. from a UART receiver), packs it into 32-bit words and issues one write per word into the program memory image.
- The image is addressed from BASE_ADDRESS, in word steps of 4 bytes.
- Holds the processor in hold/reset until a complete, valid image has been written, then releases it.

Parameters:
- MEMORY_DEPTH, 64, number of 32-bit words in program memory; maximum accepted image length.
- DATA_WIDTH, 32, word and address width.
- BASE_ADDRESS, 32'h400000, byte address of word 0 (text segment base).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start_i  in  1  one-cycle pulse; begins a load session.
- Byte_i  in  8  incoming stream byte.
- Byte_Valid_i  in  1  Byte_i is valid this cycle.
- Byte_Ready_o  out  1  loader accepts a byte this cycle.
- Mem_Write_o  out  1  write strobe to program memory.
- Mem_Address_o  out  DATA_WIDTH  byte address of the word being written.
- Mem_Data_o  out  DATA_WIDTH  word being written.
- Cpu_Hold_o  out  1  keep processor halted while 1.
- Done_o  out  1  image loaded successfully (level).
- Error_o  out  1  header rejected (level).

Behaviour:
- Reset (asynchronous, active-low):
  - State = IDLE.
  - Byte_Ready_o, Mem_Write_o, Done_o and Error_o = 0.
  - Mem_Address_o = BASE_ADDRESS; Mem_Data_o = 0.
  - Cpu_Hold_o = 1.
  - Word index and byte counter = 0.
- Byte transfer: a byte is transferred only on a cycle with Byte_Valid_i & Byte_Ready_o. A byte offered while Byte_Ready_o = 0 is not consumed and must be held by the source.
- Stream format:
  - Two header bytes give the word count N, 16 bits, MSB first.
  - Then N*4 data bytes, most-significant byte of each word first.
- States:
  - IDLE: Byte_Ready_o = 0. On Start_i go to LEN_HI and clear Done_o and Error_o.
  - LEN_HI: Byte_Ready_o = 1. On a transfer, capture N[15:8] and go to LEN_LO.
  - LEN_LO: Byte_Ready_o = 1. On a transfer, capture N[7:0].
    - If N == 0 or N > MEMORY_DEPTH, go to ERROR.
    - Otherwise go to DATA with index = 0 and byte counter = 0.
  - DATA: Byte_Ready_o = 1. Each transfer shifts the byte into the word register from the LSB side (word = {word[23:0], byte}). On the 4th byte, go to WRITE.
  - WRITE: exactly one cycle.
    - Byte_Ready_o = 0; Mem_Write_o = 1.
    - Mem_Address_o = BASE_ADDRESS + (index << 2); Mem_Data_o = packed word.
    - Then index increments. If the new index == N, go to DONE; otherwise go to DATA.
  - DONE: Done_o = 1, Cpu_Hold_o = 0. Start_i re-enters LEN_HI and sets Cpu_Hold_o = 1 again.
  - ERROR: Error_o = 1, Cpu_Hold_o stays 1. Start_i re-enters LEN_HI.
- Latency: when the 4th byte of a word transfers on cycle t, Mem_Write_o is high on cycle t+1 only. Peak throughput is therefore one word per 5 cycles.
- Mem_Write_o is never asserted outside WRITE. Mem_Address_o and Mem_Data_o hold their last values outside WRITE.
- Start_i is ignored in LEN_HI, LEN_LO, DATA and WRITE; a session cannot be aborted except by reset.
- Byte_Valid_i is ignored in IDLE, WRITE, DONE and ERROR.
- Address arithmetic is DATA_WIDTH bits and wraps modulo 2^DATA_WIDTH. No overflow occurs within legal N.
- Reset asserted mid-session: immediate return to IDLE, partial word discarded, Cpu_Hold_o = 1. Words already written stay in memory.
- N == MEMORY_DEPTH is legal; the last write goes to BASE_ADDRESS + 4*(MEMORY_DEPTH-1).

Decomposition:
- Shared package/include:
  - State encoding constants: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
  - TEXT_BASE = 32'h400000, shared with program memory and the PC reset value.
  - Header width constant (16).
- One sub-module, byte_packer: a 2-bit byte counter plus 32-bit shift register, with a word_complete pulse output. The FSM, index counter and address generation stay in program_loader.

Test Plan:
- Reset then idle: reset low → Cpu_Hold_o = 1, Done_o = 0, Error_o = 0, Mem_Write_o = 0, Mem_Address_o = 32'h400000. Bytes offered without Start_i → none accepted.
- Two-word load: Start_i, then bytes 00 02 20 08 00 05 AC 08 00 00 with Byte_Valid_i held high.
  - Write 1: 32'h20080005 at 32'h400000, one cycle after byte 6 transfers.
  - Write 2: 32'hAC080000 at 32'h400004.
  - Then Done_o = 1 and Cpu_Hold_o = 0.
- Throttled source: same stream with Byte_Valid_i toggling every other cycle. Same two writes and data; Byte_Ready_o = 0 during each WRITE cycle and no byte is lost.
- Bad headers:
  - Header 00 00 → Error_o = 1, no Mem_Write_o, Cpu_Hold_o = 1.
  - Header 00 41 (65 > 64) → same response.
- Full depth: N = 64 with incrementing words → 64 writes, last at 32'h4000FC, then Done_o = 1. Start_i pulsed mid-stream → ignored.
- Reset mid-word: after 2 data bytes, pulse reset low → IDLE, no write. A fresh Start_i plus a 1-word image writes at 32'h400000.
